exception_sequencer: RTL
========================

Name: exception_sequencer

Overview:
- Mode/exception controller that sits directly upstream of the banked-stack block.
- Owns the current mode M, the I/F mask bits, and per-mode SPSR/LR banks.
- On an exception or return it drives the SP_out → mode switch → SP_in handshake that the stack bank consumes, then redirects fetch.
- The core stalls on `busy` while a sequence runs.

Parameters:
- VEC_BASE, 32'h0000_0000, base address of the exception vector table
- RESET_MODE, 5'b10011, mode after reset (svc)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr_done  in  1  instruction boundary; requests are sampled only when this is high
- fiq  in  1  fast interrupt request, level
- irq  in  1  interrupt request, level
- und_req  in  1  undefined-instruction request, held until exc_ack
- svc_req  in  1  supervisor-call request, held until exc_ack
- eret  in  1  exception-return request, held until ret_ack
- msr_we  in  1  software write of the control byte
- msr_data  in  8  {I,F,T,M[4:0]}
- cpsr_flags  in  4  NZCV from the ALU, saved into SPSR on entry
- pc_next  in  32  address of the next sequential instruction
- M  out  5  current mode to the stack bank
- SP_out  out  1  bank the current SP out (mode M)
- SP_in  out  1  load SP for mode M
- I_bit, F_bit  out  1 each  current interrupt masks
- pc_load  out  1  one-cycle fetch redirect
- pc_target  out  32  redirect address
- flags_restore  out  4  NZCV to reload on return; valid when ret_ack=1
- exc_ack, ret_ack  out  1 each  one-cycle completion pulses
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1, synchronous):
  - M=RESET_MODE, I=1, F=1, T=0, state=IDLE.
  - All SPSR/LR banks cleared to 0.
  - Every pulse output and pc_target are 0.
- States: IDLE, E_OUT, E_SW, E_IN, E_JMP, R_OUT, R_SW, R_IN, R_JMP.
- Entry selection in IDLE when instr_done=1. Priority order:
  - fiq if F=0
  - irq if I=0
  - und_req
  - svc_req
- Target modes: fiq 10001, irq 10010, und 11011, svc 10011.
- Vectors, relative to VEC_BASE: und +0x04, svc +0x08, irq +0x18, fiq +0x1C.
- Entry sequence, one cycle per state:
  - E_OUT: SP_out=1 with the old M.
  - E_SW: M←target; SPSR[target]←{cpsr_flags,I,F,T,oldM}; LR[target]←pc_next latched at selection; I←1; F←1 only for fiq.
  - E_IN: SP_in=1 with the new M.
  - E_JMP: pc_load=1, pc_target=vector, exc_ack=1, then IDLE.
  - Entry latency: 4 cycles from selection to exc_ack.
- Return, taken in IDLE when instr_done=1, eret=1, no entry is selected, and M is one of fiq/irq/svc/und:
  - R_OUT: SP_out=1 with the current M.
  - R_SW: M, I, F, T restored from SPSR[M]; flags_restore←SPSR[M][16:13]; LR[M] latched as the return address.
  - R_IN: SP_in=1 with the restored M.
  - R_JMP: pc_load=1, pc_target=latched LR, ret_ack=1, then IDLE.
- eret in usr (10000) or sys (11111): no sequence runs; ret_ack=1 for one cycle, M unchanged, pc_load=0.
- Simultaneous eret and an enabled entry: entry wins. eret stays asserted and is taken after exc_ack if it is still legal; nesting is permitted.
- Requests arriving while busy are ignored until IDLE. Levels are re-sampled; held requests persist.
- msr_we:
  - Honoured only in IDLE when no sequence is starting.
  - Write is ignored in usr mode, except that I/F may be written in any privileged mode.
  - An illegal M encoding leaves M unchanged.
- SP_out and SP_in are never high in the same cycle and are always exactly one cycle wide.
- rst mid-sequence aborts to the reset state the same cycle; the pulses in flight drop to 0.
- SPSR layout (17 bits): [16:13] NZCV, [12] I, [11] F, [10] T, [9:5] reserved 0, [4:0] M.

Decomposition:
- Package arm_mode_pkg:
  - mode encodings MODE_USR/FIQ/IRQ/SVC/ABT/UND/SYS
  - vector offsets
  - the state enum
  - the SPSR field positions
  - function is_privileged(M) and function has_spsr(M)
- One natural sub-module, mode_bank_regs: four-entry SPSR+LR register file indexed by mode, with one write port and one read port.

Test Plan:
- Reset, then msr_we with data 8'h10 (I=0, F=0, usr) in IDLE → M=10000, I_bit=0, F_bit=0 next cycle.
- usr, pc_next=32'h100, irq=1 with instr_done → SP_out@M=10000, then M=10010, SP_in@M=10010, pc_target=32'h18, exc_ack on the 4th cycle, I_bit=1, F_bit=0.
- In irq mode, fiq=1 → nested entry to 10001, pc_target=32'h1C, F_bit=1. Then eret → M back to 10010, pc_target equals the pc_next saved at fiq entry, ret_ack=1.
- fiq=1 and irq=1 in the same cycle with I=F=0 → fiq taken. After eret returns to usr, irq is taken next (vector 32'h18).
- eret while in usr → ret_ack pulse only, no SP_out/SP_in/pc_load, M stays 10000.
- rst asserted during E_IN → next cycle M=10011, I=F=1, busy=0, SP_in=0, pc_load=0.

Source files
------------

// File: rtl/arm_mode_pkg.sv
// Mode encodings, vector offsets, sequencer states and SPSR layout shared
// by the exception sequencer and its banked SPSR/LR register file.
package arm_mode_pkg;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_ABT = 5'b10111;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [4:0] MODE_SYS = 5'b11111;

   localparam logic [31:0] VEC_OFF_UND = 32'h0000_0004;
   localparam logic [31:0] VEC_OFF_SVC = 32'h0000_0008;
   localparam logic [31:0] VEC_OFF_IRQ = 32'h0000_0018;
   localparam logic [31:0] VEC_OFF_FIQ = 32'h0000_001C;

   // SPSR field positions (17-bit word)
   localparam int SPSR_W        = 17;
   localparam int SPSR_NZCV_HI  = 16;
   localparam int SPSR_NZCV_LO  = 13;
   localparam int SPSR_I        = 12;
   localparam int SPSR_F        = 11;
   localparam int SPSR_T        = 10;
   localparam int SPSR_M_HI     = 4;

   typedef enum logic [3:0] {
      IDLE, E_OUT, E_SW, E_IN, E_JMP, R_OUT, R_SW, R_IN, R_JMP
   } seq_state_t;

   // Field order mirrors the bit positions above, MSB first
   typedef struct packed {
      logic [3:0] nzcv;
      logic       i;
      logic       f;
      logic       t;
      logic [4:0] rsvd;
      logic [4:0] m;
   } spsr_t;

   typedef struct packed {
      logic       we;
      logic [1:0] idx;
      spsr_t      spsr;
      logic [31:0] lr;
   } bank_wr_t;

   function automatic logic is_legal_mode(input logic [4:0] m);
      case (m)
         MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
         MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic is_privileged(input logic [4:0] m);
      return is_legal_mode(m) && (m != MODE_USR);
   endfunction

   // Only the four exception modes this block enters own an SPSR/LR bank
   function automatic logic has_spsr(input logic [4:0] m);
      return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) || (m == MODE_UND);
   endfunction

   function automatic logic [1:0] bank_idx(input logic [4:0] m);
      case (m)
         MODE_FIQ: return 2'd0;
         MODE_IRQ: return 2'd1;
         MODE_UND: return 2'd3;
         default:  return 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/mode_bank_regs.sv
// Four-entry SPSR+LR register file indexed by exception mode.
// One synchronous write port, one combinational read port.
module mode_bank_regs
   import arm_mode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  bank_wr_t    wr,
   input  logic [1:0]  rd_idx,
   output spsr_t       rd_spsr,
   output logic [31:0] rd_lr
);

   spsr_t       spsr_q [4];
   logic [31:0] lr_q   [4];

   // bank write on exception entry; reset clears every bank
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            spsr_q[k] <= '0;
            lr_q[k]   <= '0;
         end
      end else if (wr.we) begin
         spsr_q[wr.idx] <= wr.spsr;
         lr_q[wr.idx]   <= wr.lr;
      end
   end

   assign rd_spsr = spsr_q[rd_idx];
   assign rd_lr   = lr_q[rd_idx];

endmodule

// File: rtl/exception_sequencer.sv
// Mode/exception controller: selects entries/returns at instruction
// boundaries, drives the SP_out -> mode switch -> SP_in handshake for the
// banked stack, then redirects fetch.
module exception_sequencer
   import arm_mode_pkg::*;
#(
   parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
   parameter logic [4:0]  RESET_MODE = 5'b10011
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_done,
   input  logic        fiq,
   input  logic        irq,
   input  logic        und_req,
   input  logic        svc_req,
   input  logic        eret,
   input  logic        msr_we,
   input  logic [7:0]  msr_data,
   input  logic [3:0]  cpsr_flags,
   input  logic [31:0] pc_next,
   output logic [4:0]  M,
   output logic        SP_out,
   output logic        SP_in,
   output logic        I_bit,
   output logic        F_bit,
   output logic        pc_load,
   output logic [31:0] pc_target,
   output logic [3:0]  flags_restore,
   output logic        exc_ack,
   output logic        ret_ack,
   output logic        busy
);

   seq_state_t  state;
   logic        t_bit;
   logic [4:0]  tgt_mode;
   logic [31:0] tgt_vec;
   logic [31:0] lr_hold;

   bank_wr_t    bank_wr;
   spsr_t       rd_spsr;
   logic [31:0] rd_lr;

   logic        sel_entry, sel_ret, sel_nop_ret;
   logic [4:0]  sel_mode;
   logic [31:0] sel_off;
   logic        unused_rsvd;

   assign unused_rsvd = ^rd_spsr.rsvd;

   mode_bank_regs u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr      (bank_wr),
      .rd_idx  (bank_idx(M)),
      .rd_spsr (rd_spsr),
      .rd_lr   (rd_lr)
   );

   // request priority and start conditions, evaluated only in IDLE
   always_comb begin
      sel_mode = MODE_SVC;
      sel_off  = VEC_OFF_SVC;
      if (fiq && !F_bit) begin
         sel_mode = MODE_FIQ;  sel_off = VEC_OFF_FIQ;
      end else if (irq && !I_bit) begin
         sel_mode = MODE_IRQ;  sel_off = VEC_OFF_IRQ;
      end else if (und_req) begin
         sel_mode = MODE_UND;  sel_off = VEC_OFF_UND;
      end
      sel_entry = (state == IDLE) && instr_done &&
                  ((fiq && !F_bit) || (irq && !I_bit) || und_req || svc_req);
      // ret_ack guard stops a still-held eret from re-firing the one-cycle ack
      sel_ret     = (state == IDLE) && instr_done && eret && !sel_entry && !ret_ack && has_spsr(M);
      sel_nop_ret = (state == IDLE) && instr_done && eret && !sel_entry && !ret_ack && !has_spsr(M);
   end

   // bank write lands on the E_OUT->E_SW edge, capturing the pre-switch state
   always_comb begin
      bank_wr           = '0;
      bank_wr.we        = (state == E_OUT);
      bank_wr.idx       = bank_idx(tgt_mode);
      bank_wr.spsr.nzcv = cpsr_flags;
      bank_wr.spsr.i    = I_bit;
      bank_wr.spsr.f    = F_bit;
      bank_wr.spsr.t    = t_bit;
      bank_wr.spsr.m    = M;
      bank_wr.lr        = lr_hold;
   end

   // sequencer FSM with registered handshake/redirect outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         M             <= RESET_MODE;
         I_bit         <= 1'b1;
         F_bit         <= 1'b1;
         t_bit         <= 1'b0;
         SP_out        <= 1'b0;
         SP_in         <= 1'b0;
         pc_load       <= 1'b0;
         pc_target     <= '0;
         flags_restore <= '0;
         exc_ack       <= 1'b0;
         ret_ack       <= 1'b0;
         busy          <= 1'b0;
         tgt_mode      <= RESET_MODE;
         tgt_vec       <= '0;
         lr_hold       <= '0;
      end else begin
         SP_out  <= 1'b0;
         SP_in   <= 1'b0;
         pc_load <= 1'b0;
         exc_ack <= 1'b0;
         ret_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_entry) begin
                  state    <= E_OUT;
                  SP_out   <= 1'b1;
                  busy     <= 1'b1;
                  tgt_mode <= sel_mode;
                  tgt_vec  <= VEC_BASE + sel_off;
                  lr_hold  <= pc_next;
               end else if (sel_ret) begin
                  state  <= R_OUT;
                  SP_out <= 1'b1;
                  busy   <= 1'b1;
               end else if (sel_nop_ret) begin
                  ret_ack <= 1'b1;
               end else if (msr_we && is_privileged(M)) begin
                  I_bit <= msr_data[7];
                  F_bit <= msr_data[6];
                  t_bit <= msr_data[5];
                  if (is_legal_mode(msr_data[4:0]))
                     M <= msr_data[4:0];
               end
            end
            E_OUT: begin
               state <= E_SW;
               M     <= tgt_mode;
               I_bit <= 1'b1;
               if (tgt_mode == MODE_FIQ)
                  F_bit <= 1'b1;
            end
            E_SW: begin
               state <= E_IN;
               SP_in <= 1'b1;
            end
            E_IN: begin
               state     <= E_JMP;
               pc_load   <= 1'b1;
               pc_target <= tgt_vec;
               exc_ack   <= 1'b1;
            end
            E_JMP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            R_OUT: begin
               state         <= R_SW;
               M             <= rd_spsr.m;
               I_bit         <= rd_spsr.i;
               F_bit         <= rd_spsr.f;
               t_bit         <= rd_spsr.t;
               flags_restore <= rd_spsr.nzcv;
               lr_hold       <= rd_lr;
            end
            R_SW: begin
               state <= R_IN;
               SP_in <= 1'b1;
            end
            R_IN: begin
               state     <= R_JMP;
               pc_load   <= 1'b1;
               pc_target <= lr_hold;
               ret_ack   <= 1'b1;
            end
            R_JMP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
